// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the instruction encoder.
// Field positions follow the RV32 base instruction layout.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        FMT_I   = 2'b00,
        FMT_S   = 2'b01,
        FMT_B   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_e;

    localparam int OPC_LSB    = 0;
    localparam int RD_LSB     = 7;
    localparam int F3_LSB     = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int IMM_I_LSB  = 20;
    localparam int IMM_SH_LSB = 25;
    localparam int IMM_SL_LSB = 7;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_t;

    // True when v[31:msb] are all equal, i.e. v survives
    // truncation to msb+1 bits followed by sign extension.
    function automatic logic sext_fits(logic [31:0] v, int msb);
        logic [31:0] t;
        t = 32'($signed(v) >>> msb);
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational packer: fields plus immediate into one word,
// with a flag when the immediate does not fit the format.
module instr_enc_pack
    import instr_enc_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    // Scatter fields and immediate slices into the word
    always_comb begin
        instr = '0;
        err   = 1'b0;
        unique case (fmt)
            FMT_I: begin
                instr[OPC_LSB +: 7]    = opcode;
                instr[RD_LSB +: 5]     = rd;
                instr[F3_LSB +: 3]     = funct3;
                instr[RS1_LSB +: 5]    = rs1;
                instr[IMM_I_LSB +: 12] = imm[11:0];
                err = !sext_fits(imm, 11);
            end
            FMT_S: begin
                instr[OPC_LSB +: 7]    = opcode;
                instr[IMM_SL_LSB +: 5] = imm[4:0];
                instr[F3_LSB +: 3]     = funct3;
                instr[RS1_LSB +: 5]    = rs1;
                instr[RS2_LSB +: 5]    = rs2;
                instr[IMM_SH_LSB +: 7] = imm[11:5];
                err = !sext_fits(imm, 11);
            end
            FMT_B: begin
                instr[OPC_LSB +: 7]  = opcode;
                instr[7]             = imm[11];
                instr[11:8]          = imm[4:1];
                instr[F3_LSB +: 3]   = funct3;
                instr[RS1_LSB +: 5]  = rs1;
                instr[RS2_LSB +: 5]  = rs2;
                instr[30:25]         = imm[10:5];
                instr[31]            = imm[12];
                err = !sext_fits(imm, 12) || imm[0];
            end
            default: begin
                instr = '0;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Pipelined instruction encoder: packs at accept, buffers in an
// in-order FIFO and counts words handed to the consumer.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    enc_t             enc;
    enc_t             head;
    enc_t             mem_q [DEPTH];
    enc_t             mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;
    logic             rdy_q;
    logic             rdy_d;
    logic [CNT_W-1:0] ic_q;
    logic [CNT_W-1:0] ic_d;
    logic [CNT_W-1:0] ec_q;
    logic [CNT_W-1:0] ec_d;
    logic             push;
    logic             pop;

    instr_enc_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .instr  (enc.instr),
        .err    (enc.err)
    );

    // Handshakes and masked head-of-queue outputs
    always_comb begin
        head        = mem_q[rd_ptr_q];
        out_valid   = (count_q != '0);
        in_ready    = rdy_q;
        push        = in_valid && rdy_q;
        pop         = out_valid && out_ready;
        out_instr   = out_valid ? head.instr : '0;
        out_err     = out_valid ? head.err : 1'b0;
        instr_count = ic_q;
        err_count   = ec_q;
    end

    // FIFO next state; ready is registered from next occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rdy_d = (count_d != FULL);
    end

    // Saturating handoff counters
    always_comb begin
        ic_d = ic_q;
        ec_d = ec_q;
        if (pop && (ic_q != '1)) begin
            ic_d = ic_q + 1'b1;
        end
        if (pop && head.err && (ec_q != '1)) begin
            ec_d = ec_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            ic_q     <= '0;
            ec_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            ic_q     <= ic_d;
            ec_q     <= ec_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: behavioural queue model checked every
// cycle, directed literal cases, then randomized traffic.
module tb_instr_encoder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_ready = 1'b0;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] instr_count;
    logic [15:0] err_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_instr4;
    logic        out_err4;
    logic [3:0]  instr_count4;
    logic [3:0]  err_count4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .instr_count(instr_count), .err_count(err_count)
    );

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_err(out_err4),
        .instr_count(instr_count4), .err_count(err_count4)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  fmt;
        logic [31:0] imm;
    } ent_t;

    ent_t        q[$];
    int          n_out = 0;
    int          n_err = 0;
    bit          armed = 0;
    logic [31:0] got[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding from the instruction-set rules, value-range arithmetic
    function automatic ent_t model_enc(logic [1:0] f, logic [6:0] op,
        logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1,
        logic [4:0] rs2, logic [31:0] imm);
        ent_t e;
        int s;
        logic [31:0] base;
        s = $signed(imm);
        e.fmt = f;
        e.imm = imm;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (f)
            2'd0: begin
                e.instr = base | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
                e.err = !(s >= -2048 && s <= 2047);
            end
            2'd1: begin
                e.instr = base | (((imm >> 5) & 32'h7F) << 25)
                        | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
                e.err = !(s >= -2048 && s <= 2047);
            end
            2'd2: begin
                e.instr = base | (((imm >> 12) & 32'h1) << 31)
                        | (((imm >> 5) & 32'h3F) << 25)
                        | (32'(rs2) << 20)
                        | (((imm >> 1) & 32'hF) << 8)
                        | (((imm >> 11) & 32'h1) << 7);
                e.err = !(s >= -4096 && s <= 4095 && (s % 2 == 0));
            end
            default: begin
                e.instr = 32'h0;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] decode_imm(logic [31:0] w, logic [1:0] f);
        case (f)
            2'd0: return {{20{w[31]}}, w[31:20]};
            2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        n_out = 0;
        n_err = 0;
        armed = 0;
    end

    // Model advance on each active edge
    always @(posedge clk) begin
        bit acc;
        bit pp;
        if (!rst_n) begin
            q.delete();
            n_out = 0;
            n_err = 0;
            armed = 0;
        end else begin
            acc = in_valid && armed && (q.size() < DEPTH);
            pp = (q.size() > 0) && out_ready;
            if (pp) begin
                if (q[0].err) n_err++;
                n_out++;
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(model_enc(in_fmt, in_opcode, in_funct3,
                    in_rd, in_rs1, in_rs2, in_imm));
            end
            armed = 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        bit ev;
        bit er;
        logic [31:0] ei;
        logic ee;
        ev = rst_n && (q.size() > 0);
        er = rst_n && armed && (q.size() < DEPTH);
        ei = ev ? q[0].instr : 32'h0;
        ee = ev ? q[0].err : 1'b0;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_instr", out_instr, ei);
        chk("out_err", 32'(out_err), 32'(ee));
        chk("instr_count", 32'(instr_count), 32'(n_out > 65535 ? 65535 : n_out));
        chk("err_count", 32'(err_count), 32'(n_err > 65535 ? 65535 : n_err));
        chk("instr_count4", 32'(instr_count4), 32'(n_out > 15 ? 15 : n_out));
        chk("err_count4", 32'(err_count4), 32'(n_err > 15 ? 15 : n_err));
        chk("out_instr4", out_instr4, ei);
        chk("in_ready4", 32'(in_ready4), 32'(er));
        if (ev && !q[0].err) begin
            chk("roundtrip", decode_imm(out_instr, q[0].fmt), q[0].imm);
        end
        if (rst_n && out_valid && out_ready) got.push_back(out_instr);
    end

    task automatic push(logic [1:0] f, logic [6:0] op, logic [2:0] f3,
        logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
        logic [31:0] imm);
        bit r;
        bit done;
        done = 0;
        in_fmt = f;
        in_opcode = op;
        in_funct3 = f3;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_imm = imm;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got in_ready=0 want 1");
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_instr_count", 32'(instr_count), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);
    endtask

    initial begin
        logic [31:0] w;
        int bl[12];
        ent_t m;
        bl = '{2047, 2048, -2048, -2049, 4094, 4095,
               -4096, -4098, 4096, 0, 1, 3};

        m = model_enc(2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFF);
        chk("model_addi", m.instr, 32'hFFF30293);
        m = model_enc(2'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd7, 32'd8);
        chk("model_sw", m.instr, 32'h00712423);
        m = model_enc(2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        chk("model_beq", m.instr, 32'hFE208EE3);

        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", 32'(out_valid), 32'h0);
        chk("init_out_instr", out_instr, 32'h0);
        chk("init_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_in_ready", 32'(in_ready), 32'h1);

        out_ready = 1'b1;
        push(2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd31, 32'hFFFFFFFF);
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_instr", out_instr, 32'hFFF30293);
        chk("addi_err", 32'(out_err), 32'h0);
        push(2'd1, 7'h23, 3'd2, 5'd17, 5'd2, 5'd7, 32'd8);
        chk("sw_instr", out_instr, 32'h00712423);
        push(2'd2, 7'h63, 3'd0, 5'd9, 5'd1, 5'd2, 32'hFFFFFFFC);
        chk("beq_instr", out_instr, 32'hFE208EE3);
        chk("beq_err", 32'(out_err), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("dir_instr_count", 32'(instr_count), 32'd3);

        do_reset();
        push(2'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd2048);
        w = out_instr;
        chk("i2048_err", 32'(out_err), 32'h1);
        chk("i2048_imm", 32'(w[31:20]), 32'h800);
        push(2'd2, 7'h63, 3'd1, 5'd0, 5'd3, 5'd4, 32'd3);
        chk("b3_err", 32'(out_err), 32'h1);
        push(2'd3, 7'h7F, 3'd7, 5'd31, 5'd31, 5'd31, 32'h12345678);
        chk("rsv_instr", out_instr, 32'h0);
        chk("rsv_err", 32'(out_err), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("err3_err_count", 32'(err_count), 32'd3);
        chk("err3_instr_count", 32'(instr_count), 32'd3);

        out_ready = 1'b0;
        push(2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFF);
        push(2'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd7, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'h0);
        chk("mid_out_instr", out_instr, 32'h0);
        chk("mid_instr_count", 32'(instr_count), 32'h0);
        chk("mid_err_count", 32'(err_count), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        push(2'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd7, 32'd8);
        chk("mid_new_valid", 32'(out_valid), 32'h1);
        chk("mid_new_instr", out_instr, 32'h00712423);

        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(2'd3, 7'h13, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sat_instr_count4", 32'(instr_count4), 32'hF);
        chk("sat_err_count4", 32'(err_count4), 32'hF);
        chk("sat_instr_count16", 32'(instr_count), 32'd17);

        out_ready = 1'b0;
        got.delete();
        push(2'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFF);
        push(2'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd7, 32'd8);
        chk("bp_full_ready", 32'(in_ready), 32'h0);
        fork
            push(2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 20 && got.size() < 3; k++) @(posedge clk);
        #1;
        chk("bp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_w0", got[0], 32'hFFF30293);
            chk("bp_w1", got[1], 32'h00712423);
            chk("bp_w2", got[2], 32'hFE208EE3);
        end

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1500) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_fmt = 2'($urandom_range(0, 3));
            in_opcode = 7'($urandom);
            in_funct3 = 3'($urandom);
            in_rd = 5'($urandom);
            in_rs1 = 5'($urandom);
            in_rs2 = 5'($urandom);
            case ($urandom_range(0, 3))
                0: in_imm = $urandom;
                1: in_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                2: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                default: in_imm = 32'(bl[$urandom_range(0, 11)]);
            endcase
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V instruction encoder: the inverse of the decode-stage immediate extender. It takes instruction fields plus a 32-bit signed immediate and packs them into an I-, S- or B-type instruction word. It checks that the immediate is representable in the target format and buffers encoded words behind a valid/ready handshake. It sits between the test/boot loader and instruction-memory write port, generating program words in hardware.

## Interface
- DEPTH, 2, output buffer entries; power of two, ≥2
- CNT_W, 16, width of status counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request fields valid
- in_ready  out  1  encoder can accept request
- in_fmt  in  2  00 I, 01 S, 10 B, 11 reserved
- in_opcode  in  7  opcode, placed at [6:0]
- in_funct3  in  3  placed at [14:12]
- in_rd  in  5  I only, placed at [11:7]
- in_rs1  in  5  placed at [19:15]
- in_rs2  in  5  S/B only, placed at [24:20]
- in_imm  in  32  signed immediate
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer takes word
- out_instr  out  32  encoded instruction
- out_err  out  1  word's immediate out of range, or reserved format
- instr_count  out  CNT_W  words handed off since reset, saturating
- err_count  out  CNT_W  words with out_err handed off since reset, saturating

## Operation
- Accept on in_valid & in_ready; encode combinationally at accept, then push {instr, err} into FIFO.
- I: instr = {imm[11:0], rs1, funct3, rd, opcode}; err unless in_imm[31:11] all equal.
- S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; same range rule as I.
- B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; err unless in_imm[31:12] all equal and in_imm[0]==0.
- On range error, the packed word still uses truncated immediate bits; only out_err is raised.
- Reserved fmt: instr = 32'h0, err = 1.
- Round-trip property: when err=0, sign-extending the packed immediate field (with B bit0 = 0) returns in_imm exactly.
- Unused fields (rd for S/B, rs2 for I) are ignored.
- Handoff on out_valid & out_ready: pop FIFO; instr_count += 1; err_count += 1 if out_err. Both saturate at all-ones.
- FIFO is strictly in-order. There is no bypass: an input is never visible at the output in its accept cycle.
- in_ready = !full. When full, a simultaneous pop does not admit a push that cycle.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on out_instr with out_valid=1 after edge N, if the FIFO was empty.
- Throughput is 1 word/cycle while out_ready=1.
- out_valid, out_instr and out_err hold stable until handshake. out_instr and out_err are 0 whenever out_valid=0.
- Simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
- Full: in_ready=0 until the cycle after a pop.
- Reset (asynchronous, any time, including mid-stream): FIFO empties; out_valid=0, out_instr=0, out_err=0, instr_count=0, err_count=0, in_ready=0 while rst_n=0. in_ready=1 from the first edge after release.

## Structure
- Package instr_enc_pkg holds:
  - fmt encodings FMT_I/FMT_S/FMT_B/FMT_RSV
  - field bit-position constants
  - opcode constants OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
- Sub-module instr_enc_pack is purely combinational: fields + imm in, {instr, err} out. The top level holds the FIFO (pointers plus count) and the counters.

## Test plan
- I addi x5,x6,-1: fmt=00, opcode=7'h13, funct3=0, rd=5, rs1=6, imm=32'hFFFFFFFF -> out_instr=32'hFFF30293, out_err=0, after 1 cycle.
- S sw x7,8(x2): fmt=01, opcode=7'h23, funct3=2, rs1=2, rs2=7, imm=8 -> 32'h00712423, err=0. B beq x1,x2,-4: fmt=10, opcode=7'h63, rs1=1, rs2=2, imm=32'hFFFFFFFC -> 32'hFE208EE3, err=0.
- Errors:
  - I imm=2048 -> err=1, bits[31:20]=12'h800.
  - B imm=3 -> err=1.
  - fmt=11 -> instr=0, err=1.
  - After handoff of all three: err_count=3, instr_count=3.
- Backpressure, DEPTH=2, out_ready=0: issue 3 requests -> in_ready=0 after the 2nd accept. Raise out_ready -> 3 words emerge in order, none lost or duplicated.
- Reset mid-stream: 2 words queued, pull rst_n low between edges -> out_valid=0 immediately, counters=0. After release, in_ready=1, and a new word emerges with 1-cycle latency.
- Saturation, CNT_W=4: hand off 17 error words -> instr_count=err_count=4'hF.
